// File: rtl/axi_rd_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter_pkg
// Shared definitions for the two-requester AXI read-channel arbiter:
//   - FSM state encoding (IDLE / ADDR / DATA)
//   - AXI read response codes
//   - helper turning the 1-bit owner index into the one-hot grant vector
// -----------------------------------------------------------------------------
package axi_rd_arbiter_pkg;

   // FSM state encoding, kept as plain constants so older tools and
   // waveform scripts that match on raw values keep working.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   // AXI RRESP codes; the arbiter forwards these untouched.
   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   // Owner index 0 -> 2'b01 (m0, IFU), 1 -> 2'b10 (m1, LSU).
   function automatic logic [1:0] owner_onehot(input logic owner);
      return owner ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin pick, purely combinational.
// Ports:
//   i_req[1:0]    request vector (bit N = requester N wants the slave)
//   i_last_grant  index of the requester that completed the previous transfer
//   o_valid       at least one request present
//   o_pick        index of the chosen requester (meaningful when o_valid=1)
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   output logic       o_valid,
   output logic       o_pick
);

   assign o_valid = |i_req;

   // On a tie the requester that was not served last wins; with a single
   // request the lone requester wins, which is simply i_req[1].
   assign o_pick = (&i_req) ? ~i_last_grant : i_req[1];

endmodule

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
// Shares one AXI read slave between two requesters: m0 (IFU) and m1 (LSU).
// One transaction at a time: address phase, then data beats until RLAST,
// then at least one idle cycle before the next owner is chosen.
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   i_mN_arvalid/o_mN_arready    requester address handshake
//   i_mN_araddr/i_mN_arlen       requester address and burst length minus 1
//   o_mN_rvalid/i_mN_rready      requester data handshake
//   o_mN_rdata/rresp/rlast       read data, broadcast to both requesters
//   o_s_arvalid/i_s_arready      slave address handshake
//   o_s_araddr/o_s_arlen         address/length muxed from the owner
//   i_s_rvalid/o_s_rready        slave data handshake
//   i_s_rdata/rresp/rlast        slave read data
//   o_grant                      one-hot owner in ADDR/DATA, 00 when idle
// -----------------------------------------------------------------------------
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   // m0: instruction fetch
   input  logic              i_m0_arvalid,
   output logic              o_m0_arready,
   input  logic [ADDR_W-1:0] i_m0_araddr,
   input  logic [7:0]        i_m0_arlen,
   output logic              o_m0_rvalid,
   input  logic              i_m0_rready,
   output logic [DATA_W-1:0] o_m0_rdata,
   output logic [1:0]        o_m0_rresp,
   output logic              o_m0_rlast,
   // m1: load/store
   input  logic              i_m1_arvalid,
   output logic              o_m1_arready,
   input  logic [ADDR_W-1:0] i_m1_araddr,
   input  logic [7:0]        i_m1_arlen,
   output logic              o_m1_rvalid,
   input  logic              i_m1_rready,
   output logic [DATA_W-1:0] o_m1_rdata,
   output logic [1:0]        o_m1_rresp,
   output logic              o_m1_rlast,
   // shared slave
   output logic              o_s_arvalid,
   output logic [ADDR_W-1:0] o_s_araddr,
   output logic [7:0]        o_s_arlen,
   input  logic              i_s_arready,
   input  logic              i_s_rvalid,
   input  logic [DATA_W-1:0] i_s_rdata,
   input  logic [1:0]        i_s_rresp,
   input  logic              i_s_rlast,
   output logic              o_s_rready,
   // current owner
   output logic [1:0]        o_grant
);

   logic [1:0] r_state;
   logic       r_owner;
   logic       r_last_grant;

   logic       w_req_valid;
   logic       w_pick;
   logic       w_own_arvalid;
   logic       w_own_rready;
   logic       w_last_beat;

   rr_arb2 u_rr_arb2 (
      .i_req        ({i_m1_arvalid, i_m0_arvalid}),
      .i_last_grant (r_last_grant),
      .o_valid      (w_req_valid),
      .o_pick       (w_pick)
   );

   assign w_own_arvalid = r_owner ? i_m1_arvalid : i_m0_arvalid;
   assign w_own_rready  = r_owner ? i_m1_rready  : i_m0_rready;

   // s_rready is the owner's rready, so this is the final-beat handshake.
   assign w_last_beat = i_s_rvalid & w_own_rready & i_s_rlast;

   // NOTE: state registers use non-blocking (<=) so every register samples
   // the pre-edge values; blocking here would make results depend on order.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;   // m0 wins the first tie after reset
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_req_valid) begin
                  r_owner <= w_pick;
                  r_state <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               // A withdrawn request releases the slave without touching
               // r_last_grant, so the round-robin order is not disturbed.
               if (!w_own_arvalid)
                  r_state <= ST_IDLE;
               else if (i_s_arready)
                  r_state <= ST_DATA;
            end
            ST_DATA: begin
               if (w_last_beat) begin
                  r_last_grant <= r_owner;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Address channel toward the slave always follows the owner; it is only
   // qualified by o_s_arvalid, which is low outside ADDR.
   assign o_s_araddr = r_owner ? i_m1_araddr : i_m0_araddr;
   assign o_s_arlen  = r_owner ? i_m1_arlen  : i_m0_arlen;

   // Read payload is broadcast; only the owner sees rvalid.
   assign o_m0_rdata = i_s_rdata;
   assign o_m0_rresp = i_s_rresp;
   assign o_m0_rlast = i_s_rlast;
   assign o_m1_rdata = i_s_rdata;
   assign o_m1_rresp = i_s_rresp;
   assign o_m1_rlast = i_s_rlast;

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      o_grant      = 2'b00;
      o_s_arvalid  = 1'b0;
      o_m0_arready = 1'b0;
      o_m1_arready = 1'b0;
      o_s_rready   = 1'b0;
      o_m0_rvalid  = 1'b0;
      o_m1_rvalid  = 1'b0;
      case (r_state)
         ST_ADDR: begin
            o_grant     = owner_onehot(r_owner);
            o_s_arvalid = w_own_arvalid;
            if (r_owner) o_m1_arready = i_s_arready;
            else         o_m0_arready = i_s_arready;
         end
         ST_DATA: begin
            o_grant    = owner_onehot(r_owner);
            o_s_rready = w_own_rready;
            if (r_owner) o_m1_rvalid = i_s_rvalid;
            else         o_m0_rvalid = i_s_rvalid;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, read address width.
REQ-002 Parameter DATA_W, default 32, read data width.
REQ-003 clock  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 m{0,1}_arvalid  input  1  requester address valid; m0 is IFU, m1 is LSU.
REQ-006 m{0,1}_arready  output  1  address accepted.
REQ-007 m{0,1}_araddr  input  ADDR_W  read address.
REQ-008 m{0,1}_arlen  input  8  burst length minus 1.
REQ-009 m{0,1}_rvalid  output  1  read data valid.
REQ-010 m{0,1}_rready  input  1  requester accepts data.
REQ-011 m{0,1}_rdata  output  DATA_W  read data.
REQ-012 m{0,1}_rresp  output  2  read response.
REQ-013 m{0,1}_rlast  output  1  last beat.
REQ-014 s_arvalid, s_araddr, s_arlen  output  1/ADDR_W/8  to shared slave.
REQ-015 s_arready  input  1  slave address ready.
REQ-016 s_rvalid, s_rdata, s_rresp, s_rlast  input  1/DATA_W/2/1  from slave.
REQ-017 s_rready  output  1  to slave.
REQ-018 grant  output  2  one-hot current owner; 00 when idle.

Function
REQ-019 The FSM SHALL have states IDLE, ADDR and DATA, plus a 1-bit owner register and a 1-bit last_grant register.
REQ-020 IDLE: all s_/m_ valid and ready outputs 0; grant=00.
REQ-021 IDLE with exactly one mN_arvalid=1: owner<=N, next state ADDR.
REQ-022 IDLE with both arvalid=1: owner<=!last_grant (round-robin), next state ADDR.
REQ-023 ADDR: s_arvalid=owner arvalid; s_araddr/s_arlen muxed from owner; owner arready=s_arready; non-owner arready=0.
REQ-024 Latency: mN_arvalid rising in IDLE SHALL give s_arvalid=1 exactly one cycle later.
REQ-025 ADDR with s_arvalid&&s_arready: next state DATA.
REQ-026 ADDR with owner arvalid=0 (withdrawn): return to IDLE; last_grant unchanged.
REQ-027 DATA: s_arvalid=0; owner rvalid=s_rvalid; s_rready=owner rready (combinational); non-owner rvalid=0; rdata/rresp/rlast driven to both requesters.
REQ-028 DATA with s_rvalid&&s_rready&&s_rlast: last_grant<=owner, next state IDLE.
REQ-029 Non-last beats (rlast=0) SHALL keep DATA; bursts of arlen+1 beats pass unbroken.
REQ-030 rresp SHALL be forwarded unmodified; error responses do not alter sequencing.
REQ-031 A requester raising arvalid during ADDR/DATA of the other SHALL wait, arready=0, until the next IDLE.
REQ-032 Minimum one IDLE cycle between consecutive transactions; no transaction overlap.
REQ-033 grant=one-hot(owner) in ADDR and DATA.

Reset
REQ-034 Reset SHALL force state IDLE, owner=0, last_grant=1 (m0 wins first tie); all outputs as in REQ-020.
REQ-035 Reset mid-transaction SHALL abandon the in-flight burst without completing it; the slave shares the same reset.

Structure
REQ-036 The state encoding (IDLE/ADDR/DATA) and the AXI resp codes SHALL live in the shared package.
REQ-037 A single sub-module rr_arb2 (2-way round-robin pick from req[1:0] and last_grant) is allowed; the rest is flat.

Verification
REQ-038 m0 araddr=0x8000_0000 alone, s_arready=1, single beat rdata=0x0000_0513, rlast=1 -> s_arvalid one cycle after request, m0_rdata=0x0000_0513, grant 01 then 00.
REQ-039 m0 and m1 raise arvalid in the same cycle after reset -> m0 served first, then m1; grant 01, 00, 10.
REQ-040 Both requesters hold arvalid continuously for 4 transactions -> grant order m0, m1, m0, m1.
REQ-041 m1 burst arlen=3, m0 requests at beat 2 -> all 4 beats reach m1; m0_arready stays 0 until IDLE, then m0 is served.
REQ-042 m0 rready=0 for 3 cycles with s_rvalid=1 -> s_rready=0, data held, completes when rready=1.
REQ-043 reset asserted in DATA -> next cycle state IDLE, all valids 0, grant 00, and a fresh request is served normally.
